// File: rtl/clk_en_divider_pkg.sv
// Shared types and reset-divisor helper for the clock-enable divider.
package clk_div_pkg;

   localparam int DIV_W_DEFAULT = 16;

   typedef logic [DIV_W_DEFAULT-1:0] div_t;

   // Legacy power-of-two divisor for channel k (k=0 -> 1).
   function automatic logic [31:0] legacy_div(input int k);
      return 32'd1 << k;
   endfunction

endpackage

// File: rtl/clk_en_divider_if.sv
// Configuration / enable bus between the divider and its consumers.
interface clk_en_divider_if #(
   parameter int NUM_CH = 4,
   parameter int DIV_W  = 16
);
   localparam int CH_W = $clog2(NUM_CH) + 1;

   logic              cfg_we;
   logic [CH_W-1:0]   cfg_ch;
   logic [DIV_W-1:0]  cfg_div;
   logic              sync_restart;
   logic              cfg_ack;
   logic              cfg_err;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] sq;

   modport master (
      output cfg_we, cfg_ch, cfg_div, sync_restart,
      input  cfg_ack, cfg_err, tick, sq
   );

   modport slave (
      input  cfg_we, cfg_ch, cfg_div, sync_restart,
      output cfg_ack, cfg_err, tick, sq
   );

endinterface

// File: rtl/clk_en_divider_channel.sv
// One divider channel: divisor, pending divisor, down-counter, square wave.
module clk_en_channel
   import clk_div_pkg::*;
#(
   parameter int DIV_W       = 16,
   parameter int LEGACY_INIT = 1,
   parameter int CH          = 0
) (
   input  logic             cin,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [DIV_W-1:0] wr_div,
   input  logic             restart,
   output logic             tick,
   output logic             sq
);

   localparam logic [DIV_W-1:0] RST_DIV =
      (LEGACY_INIT != 0) ? DIV_W'(legacy_div(CH)) : '0;

   logic [DIV_W-1:0] div;
   logic [DIV_W-1:0] pend;
   logic             pend_vld;
   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] nxt_div;

   function automatic logic [DIV_W-1:0] load_val(input logic [DIV_W-1:0] d);
      return (d == '0) ? '0 : d - DIV_W'(1);
   endfunction

   // A write landing on the terminal or restart edge takes effect on that edge.
   assign nxt_div = wr_en ? wr_div : (pend_vld ? pend : div);

   always_ff @(posedge cin) begin
      if (reset) begin
         div      <= RST_DIV;
         cnt      <= load_val(RST_DIV);
         pend     <= '0;
         pend_vld <= 1'b0;
         sq       <= 1'b0;
      end else if (restart) begin
         div      <= nxt_div;
         cnt      <= load_val(nxt_div);
         pend_vld <= 1'b0;
         sq       <= 1'b0;
      end else if (div == '0) begin
         if (wr_en) begin
            div <= wr_div;
            cnt <= load_val(wr_div);
         end
      end else if (cnt == '0) begin
         div      <= nxt_div;
         cnt      <= load_val(nxt_div);
         pend_vld <= 1'b0;
         sq       <= ~sq;
      end else begin
         cnt <= cnt - DIV_W'(1);
         if (wr_en) begin
            pend     <= wr_div;
            pend_vld <= 1'b1;
         end
      end
   end

   assign tick = !reset && (cnt == '0) && (div != '0);

endmodule

// File: rtl/clk_en_divider.sv
// Multi-channel clock-enable generator: write decode, range check, ack/err flops.
module clk_en_divider
   import clk_div_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int DIV_W       = DIV_W_DEFAULT,
   parameter int LEGACY_INIT = 1
) (
   input  logic             cin,
   input  logic             reset,
   clk_en_divider_if.slave  bus
);

   localparam int CH_W = $clog2(NUM_CH) + 1;

   logic              wr_acc;
   logic              ack_p1;
   logic              err_p1;
   logic [NUM_CH-1:0] tick_v;
   logic [NUM_CH-1:0] sq_v;

   assign wr_acc = bus.cfg_we && (bus.cfg_ch < CH_W'(NUM_CH));

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      clk_en_channel #(
         .DIV_W       (DIV_W),
         .LEGACY_INIT (LEGACY_INIT),
         .CH          (k)
      ) u_ch (
         .cin     (cin),
         .reset   (reset),
         .wr_en   (wr_acc && (bus.cfg_ch == CH_W'(k))),
         .wr_div  (bus.cfg_div),
         .restart (bus.sync_restart),
         .tick    (tick_v[k]),
         .sq      (sq_v[k])
      );
   end

   // Write response stage
   always_ff @(posedge cin) begin
      if (reset) begin
         ack_p1 <= 1'b0;
         err_p1 <= 1'b0;
      end else begin
         ack_p1 <= wr_acc;
         err_p1 <= bus.cfg_we && !wr_acc;
      end
   end

   assign bus.cfg_ack = ack_p1;
   assign bus.cfg_err = err_p1;
   assign bus.tick    = tick_v;
   assign bus.sq      = sq_v;

endmodule

// File: tb/tb_clk_en_divider.sv
// Bench for clk_en_divider: vector table, directed corner sequences, random run vs schedule model.
module tb_clk_en_divider;

   localparam int NUM_CH      = 4;
   localparam int DIV_W       = 16;
   localparam int LEGACY_INIT = 1;
   localparam int CH_W        = $clog2(NUM_CH) + 1;

   logic cin;
   logic reset;

   clk_en_divider_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

   clk_en_divider #(
      .NUM_CH      (NUM_CH),
      .DIV_W       (DIV_W),
      .LEGACY_INIT (LEGACY_INIT)
   ) dut (
      .cin   (cin),
      .reset (reset),
      .bus   (bus)
   );

   initial cin = 1'b0;
   always #5 cin = ~cin;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at time %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: each channel keeps the absolute cycle of its next tick.
   int              m_div  [NUM_CH];
   int              m_pend [NUM_CH];
   bit              m_pv   [NUM_CH];
   int              m_next [NUM_CH];
   logic [NUM_CH-1:0] m_sq;
   logic            m_ack, m_err;
   int              tc;
   bit              m_valid = 0;

   function automatic logic [NUM_CH-1:0] m_tick();
      logic [NUM_CH-1:0] v;
      for (int k = 0; k < NUM_CH; k++) v[k] = (m_div[k] != 0) && (m_next[k] == tc);
      return v;
   endfunction

   task automatic model_step(input logic we, input int ch, input int dv, input logic rs, input logic rst);
      logic [NUM_CH-1:0] tk;
      bit acc;
      int d;
      if (rst) begin
         for (int k = 0; k < NUM_CH; k++) begin
            m_div[k]  = (LEGACY_INIT != 0) ? (1 << k) : 0;
            m_pv[k]   = 0;
            m_next[k] = m_div[k] - 1;
         end
         m_sq = '0; m_ack = 0; m_err = 0; tc = 0; m_valid = 1;
         return;
      end
      tk  = m_tick();
      acc = we && (ch < NUM_CH);
      for (int k = 0; k < NUM_CH; k++) begin
         bit wr;
         wr = acc && (ch == k);
         d  = wr ? dv : (m_pv[k] ? m_pend[k] : m_div[k]);
         if (rs) begin
            m_div[k] = d; m_pv[k] = 0; m_sq[k] = 1'b0; m_next[k] = tc + d;
         end else if (m_div[k] == 0) begin
            if (wr) begin m_div[k] = dv; m_next[k] = tc + dv; end
         end else if (tk[k]) begin
            m_div[k] = d; m_pv[k] = 0; m_sq[k] = ~m_sq[k]; m_next[k] = tc + d;
         end else if (wr) begin
            m_pend[k] = dv; m_pv[k] = 1;
         end
      end
      m_ack = acc;
      m_err = we && !acc;
      tc++;
   endtask

   logic [NUM_CH-1:0] obs_tick, obs_sq;
   logic              obs_ack, obs_err;

   // One clock cycle: apply inputs, sample at the falling edge, compare with the model.
   task automatic drive(input logic we, input int ch, input int dv, input logic rs, input logic rst);
      reset            = rst;
      bus.cfg_we       = we;
      bus.cfg_ch       = CH_W'(ch);
      bus.cfg_div      = DIV_W'(dv);
      bus.sync_restart = rs;
      @(negedge cin);
      obs_tick = bus.tick; obs_sq = bus.sq; obs_ack = bus.cfg_ack; obs_err = bus.cfg_err;
      if (m_valid) begin
         chk("model_tick", 32'(obs_tick), rst ? 32'd0 : 32'(m_tick()));
         chk("model_sq",   32'(obs_sq),   32'(m_sq));
         chk("model_ack",  32'(obs_ack),  32'(m_ack));
         chk("model_err",  32'(obs_err),  32'(m_err));
      end
      model_step(we, ch, dv, rs, rst);
      @(posedge cin);
      #1;
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 1);
   endtask

   typedef struct {
      logic       we;
      int         ch;
      int         dv;
      logic       rs;
      logic [3:0] tick;
      logic [3:0] sq;
      logic       ack;
      logic       err;
   } vec_t;

   vec_t tbl [10];

   initial begin
      tbl[0] = '{1'b0, 0, 0, 1'b0, 4'h1, 4'h0, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 0, 0, 1'b0, 4'h3, 4'h1, 1'b0, 1'b0};
      tbl[2] = '{1'b0, 0, 0, 1'b0, 4'h1, 4'h2, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 7, 5, 1'b0, 4'h7, 4'h3, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 0, 0, 1'b0, 4'h1, 4'h4, 1'b0, 1'b1};
      tbl[5] = '{1'b1, 4, 9, 1'b0, 4'h3, 4'h5, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 0, 0, 1'b0, 4'h1, 4'h6, 1'b0, 1'b1};
      tbl[7] = '{1'b0, 0, 0, 1'b0, 4'hF, 4'h7, 1'b0, 1'b0};
      tbl[8] = '{1'b1, 0, 1, 1'b0, 4'h1, 4'h8, 1'b0, 1'b0};
      tbl[9] = '{1'b0, 0, 0, 1'b0, 4'h3, 4'h9, 1'b1, 1'b0};

      // Legacy reset pattern, out-of-range writes, one accepted write
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].we, tbl[i].ch, tbl[i].dv, tbl[i].rs, 1'b0);
         chk("tbl_tick", 32'(obs_tick), 32'(tbl[i].tick));
         chk("tbl_sq",   32'(obs_sq),   32'(tbl[i].sq));
         chk("tbl_ack",  32'(obs_ack),  32'(tbl[i].ack));
         chk("tbl_err",  32'(obs_err),  32'(tbl[i].err));
      end

      // ch2 4 -> 5 mid-period: old period completes, then every 5
      do_reset();
      for (int t = 0; t <= 18; t++) begin
         drive(t == 5, 2, 5, 0, 0);
         chk("A_tick2", 32'(obs_tick[2]), 32'(t inside {3, 7, 12, 17}));
         chk("A_ack",   32'(obs_ack),     32'(t == 6));
      end

      // ch1 switched off (final tick, sq frozen), then restarted with div 3
      do_reset();
      for (int t = 0; t <= 17; t++) begin
         drive((t == 4) || (t == 10), 1, (t == 4) ? 0 : 3, 0, 0);
         chk("B_tick1", 32'(obs_tick[1]), 32'(t inside {1, 3, 5, 13, 16}));
         chk("B_sq1",   32'(obs_sq[1]),
             32'((t >= 2 && t <= 3) || (t >= 6 && t <= 13) || (t == 17)));
         chk("B_ack",   32'(obs_ack), 32'((t == 5) || (t == 11)));
      end

      // sync_restart with ch2=3, ch3=8 out of phase, plus same-cycle write ch1=6
      do_reset();
      for (int t = 0; t <= 57; t++) begin
         drive((t == 0) || (t == 9), (t == 0) ? 2 : 1, (t == 0) ? 3 : 6, t == 9, 0);
         if (t == 10) begin
            chk("D_sq_cleared", 32'(obs_sq), 32'd0);
            chk("D_ack", 32'(obs_ack), 32'd1);
         end
         if (t >= 10) begin
            chk("D_tick1", 32'(obs_tick[1]), 32'(((t - 10) % 6) == 5));
            chk("D_tick2", 32'(obs_tick[2]), 32'(((t - 10) % 3) == 2));
            chk("D_tick3", 32'(obs_tick[3]), 32'(((t - 10) % 8) == 7));
         end
      end

      // Reset mid-run with a pending write: pending dropped, ticks held low
      do_reset();
      for (int t = 0; t <= 3; t++) drive(t == 2, 3, 3, 0, 0);
      for (int t = 0; t < 2; t++) begin
         drive(0, 0, 0, 0, 1);
         chk("E_tick_in_reset", 32'(obs_tick), 32'd0);
      end
      for (int t = 0; t <= 9; t++) begin
         drive(0, 0, 0, 0, 0);
         chk("E_tick3", 32'(obs_tick[3]), 32'(t == 7));
      end

      // Random traffic against the model
      do_reset();
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 3) == 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 9)),
               $urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
